mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
Pipelined MEM stage, successor to the combinational pass-through MEM stage. It executes loads and stores over a request/acknowledge data-memory bus with variable latency, and aligns sub-word data both ways. It raises stall requests to the pipeline controller and forwards results to ID. It sits between the EX/MEM and MEM/WB registers.

Parameters:
ADDR_W, 32, data-memory address width
REG_ADDR_W, 5, register-file address width
TIMEOUT, 255, maximum WAIT cycles before a bus error (1..2^CNT_W-1)
CNT_W, 8, wait-counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
mem_op_i  in  4  NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, SB=6, SH=7, SW=8; all others treated as NONE
mem_addr_i  in  ADDR_W  effective address
store_data_i  in  32  rt value for stores
waddr_i / we_i / wdata_i  in  REG_ADDR_W / 1 / 32  writeback request from EX
stall_i  in  1  MEM/WB hold from controller
waddr_o / we_o / wdata_o  out  REG_ADDR_W / 1 / 32  to MEM/WB
waddr_id_o / we_id_o / wdata_id_o  out  REG_ADDR_W / 1 / 32  forwarding to ID
stallreq_o  out  1  stall request to controller
exc_misalign_o  out  1  misaligned access, 1-cycle pulse
exc_buserr_o  out  1  bus timeout, 1-cycle pulse
dm_req_o  out  1  bus request
dm_we_o  out  1  write strobe
dm_addr_o  out  ADDR_W  word-aligned address (low 2 bits = 0)
dm_sel_o  out  4  byte enables
dm_wdata_o  out  32  replicated store data
dm_ack_i  in  1  transfer complete
dm_rdata_i  in  32  read word

Behaviour:
- Reset (rst=0, async): state=IDLE, wait counter=0, latched data=0. All outputs 0; waddr outputs = NOP address 0.
- Byte lanes are big-endian. Byte at addr[1:0]=0 is bits 31:24. Half at addr[1]=0 is bits 31:16.
- Store data: SB replicates the byte x4; SH replicates the half x2; SW passes through.
- Store sel: SB gives 4'b1000>>addr[1:0]; SH gives 4'b1100 or 4'b0011; SW gives 4'b1111.
- Load sel is 4'b1111. Loads extract the lane, then sign-extend (LB/LH) or zero-extend (LBU/LHU).
- Misaligned access (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0):
  - no bus request, we_o=0, exc_misalign_o=1 for that cycle;
  - state stays IDLE, no stall.
- NONE: combinational pass-through, zero latency. Outputs: waddr_o=waddr_i, we_o=we_i, wdata_o=wdata_i; ID outputs are identical.
- FSM states IDLE, WAIT, HOLD:
  - IDLE + aligned memory op: assert dm_req_o and stallreq_o combinationally, with the address, sel, we and wdata driven.
    - If dm_ack_i is also 1 (zero-wait): complete in the same cycle, stallreq_o=0.
    - Otherwise go to WAIT.
  - WAIT: dm_req_o and all dm_* outputs held stable; stallreq_o=1; counter increments each cycle.
    - On dm_ack_i: complete.
    - If the counter reaches TIMEOUT without ack: drop the request, pulse exc_buserr_o, we_o=0, go to IDLE.
  - Complete:
    - Loads drive we_o=we_i and wdata_o = the aligned load value. Stores drive we_o=0.
    - stallreq_o deasserts in the completion cycle.
    - If stall_i=1 at completion, latch the result and go to HOLD. Otherwise go to IDLE.
  - HOLD: dm_req_o=0; outputs come from the latch; stallreq_o=0. Return to IDLE when stall_i=0. No new access is issued while in HOLD.
- Forwarding: we_id_o is 0 while a load is outstanding (IDLE-not-acked or WAIT). Otherwise the ID outputs equal the MEM/WB outputs.
- dm_ack_i seen in IDLE or HOLD with no request outstanding is ignored.
- Asserting reset mid-WAIT aborts the access: dm_req_o drops immediately and no exception is raised.

Decomposition:
- Shared defines: the mem_op encodings, the NOP register address and the ZeroWord constant go in the common defines include.
- One natural sub-module, mem_align: purely combinational. Computes store replicate/sel, load extract/extend and the misalign flag. Reused by a future cache.

Test Plan:
- Pass-through: NONE, waddr=3, we=1, wdata=0x1234 -> same cycle we_o=1, wdata_o=0x1234, ID outputs equal, dm_req_o=0.
- LB sign-extend, zero-wait: addr=0x101, rdata=0x11_80_22_33, ack in the same cycle -> wdata_o=0xFFFFFF80, stallreq_o=0.
- LHU with 3-cycle ack: addr=0x102, rdata=0xAAAA_BEEF -> stallreq_o=1 for 3 cycles and we_id_o=0 throughout. At ack, wdata_o=0x0000BEEF and stall drops.
- SB: addr=0x203, data=0x5A -> dm_sel_o=0001, dm_wdata_o=0x5A5A5A5A, dm_addr_o=0x200, we_o=0.
- Misaligned SW at 0x102 -> exc_misalign_o=1 for 1 cycle, dm_req_o=0.
- Timeout and HOLD:
  - No ack for TIMEOUT cycles -> exc_buserr_o pulses and req drops.
  - Separately: ack while stall_i=1 for 2 cycles -> HOLD keeps wdata_o stable and issues no second request.
  - Reset asserted mid-WAIT -> outputs are 0 immediately.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: memory-op encodings, NOP register
// address, zero word and the access-FSM state type.
package mem_access_pkg;

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LB   = 4'd1;
    localparam logic [3:0] OP_LBU  = 4'd2;
    localparam logic [3:0] OP_LH   = 4'd3;
    localparam logic [3:0] OP_LHU  = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_SB   = 4'd6;
    localparam logic [3:0] OP_SH   = 4'd7;
    localparam logic [3:0] OP_SW   = 4'd8;

    localparam int          NOP_REG_ADDR = 0;
    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    function automatic logic op_is_load(input logic [3:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
               (op == OP_LHU) || (op == OP_LW);
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mem_align.sv
// Big-endian sub-word alignment: store lane replication and byte enables,
// load lane extraction with sign/zero extension, and the misalign check.
module mem_align
    import mem_access_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  lane,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misalign,
    output logic        is_load,
    output logic        is_store
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        is_load   = op_is_load(op);
        is_store  = op_is_store(op);
        sel       = 4'b0000;
        wdata     = ZERO_WORD;
        load_data = ZERO_WORD;
        misalign  = 1'b0;
        // lane 0 is the most significant byte, so shift by (3 - lane) bytes
        byte_v    = 8'(rdata >> {~lane, 3'b000});
        half_v    = lane[1] ? rdata[15:0] : rdata[31:16];

        case (op)
            OP_LB: begin
                sel       = 4'b1111;
                load_data = {{24{byte_v[7]}}, byte_v};
            end
            OP_LBU: begin
                sel       = 4'b1111;
                load_data = {24'h000000, byte_v};
            end
            OP_LH: begin
                sel       = 4'b1111;
                misalign  = lane[0];
                load_data = {{16{half_v[15]}}, half_v};
            end
            OP_LHU: begin
                sel       = 4'b1111;
                misalign  = lane[0];
                load_data = {16'h0000, half_v};
            end
            OP_LW: begin
                sel       = 4'b1111;
                misalign  = |lane;
                load_data = rdata;
            end
            OP_SB: begin
                sel   = 4'b1000 >> lane;
                wdata = {4{store_data[7:0]}};
            end
            OP_SH: begin
                misalign = lane[0];
                sel      = lane[1] ? 4'b0011 : 4'b1100;
                wdata    = {2{store_data[15:0]}};
            end
            OP_SW: begin
                misalign = |lane;
                sel      = 4'b1111;
                wdata    = store_data;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Pipelined MEM stage: runs loads/stores over a variable-latency req/ack bus,
// stalls the pipeline while waiting, and holds its result while MEM/WB is held.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int TIMEOUT    = 255,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            mem_op_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    input  logic [31:0]           store_data_i,
    input  logic [REG_ADDR_W-1:0] waddr_i,
    input  logic                  we_i,
    input  logic [31:0]           wdata_i,
    input  logic                  stall_i,
    output logic [REG_ADDR_W-1:0] waddr_o,
    output logic                  we_o,
    output logic [31:0]           wdata_o,
    output logic [REG_ADDR_W-1:0] waddr_id_o,
    output logic                  we_id_o,
    output logic [31:0]           wdata_id_o,
    output logic                  stallreq_o,
    output logic                  exc_misalign_o,
    output logic                  exc_buserr_o,
    output logic                  dm_req_o,
    output logic                  dm_we_o,
    output logic [ADDR_W-1:0]     dm_addr_o,
    output logic [3:0]            dm_sel_o,
    output logic [31:0]           dm_wdata_o,
    input  logic                  dm_ack_i,
    input  logic [31:0]           dm_rdata_i,
    output logic [1:0]            dbg_state_o
);

    // Bus handshake: dm_req_o rises with address/sel/we/wdata valid and all of
    // them stay constant until the cycle dm_ack_i is seen high (the transfer
    // completes in that cycle) or the wait counter expires; an ack with no
    // request outstanding is ignored.
    typedef struct packed {
        logic [3:0]            op;
        logic [ADDR_W-1:0]     addr;
        logic [31:0]           sdata;
        logic [REG_ADDR_W-1:0] waddr;
        logic                  we;
    } req_t;

    state_t                state, state_next;
    logic [CNT_W-1:0]      cnt;
    req_t                  req_q, req_in, cur;
    logic [REG_ADDR_W-1:0] hold_waddr;
    logic                  hold_we;
    logic [31:0]           hold_wdata;

    logic        issue, complete, load_pending;
    logic [3:0]  al_sel;
    logic [31:0] al_wdata, al_load;
    logic        al_misalign, al_is_load, al_is_store;

    always_comb begin
        req_in.op    = mem_op_i;
        req_in.addr  = mem_addr_i;
        req_in.sdata = store_data_i;
        req_in.waddr = waddr_i;
        req_in.we    = we_i;
        // While waiting, drive the bus from the captured request so it cannot move
        cur = (state == ST_WAIT) ? req_q : req_in;
    end

    mem_align u_align (
        .op         (cur.op),
        .lane       (cur.addr[1:0]),
        .store_data (cur.sdata),
        .rdata      (dm_rdata_i),
        .sel        (al_sel),
        .wdata      (al_wdata),
        .load_data  (al_load),
        .misalign   (al_misalign),
        .is_load    (al_is_load),
        .is_store   (al_is_store)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            req_q      <= '0;
            hold_waddr <= '0;
            hold_we    <= 1'b0;
            hold_wdata <= ZERO_WORD;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && dm_req_o && !dm_ack_i)
                req_q <= req_in;
            if (state == ST_WAIT && dm_req_o && !dm_ack_i)
                cnt <= cnt + 1'b1;
            else
                cnt <= '0;
            if (complete && stall_i) begin
                hold_waddr <= waddr_o;
                hold_we    <= we_o;
                hold_wdata <= wdata_o;
            end
        end
    end

    always_comb begin
        state_next     = state;
        issue          = 1'b0;
        complete       = 1'b0;
        load_pending   = 1'b0;
        dm_req_o       = 1'b0;
        dm_we_o        = 1'b0;
        dm_addr_o      = '0;
        dm_sel_o       = 4'b0000;
        dm_wdata_o     = ZERO_WORD;
        stallreq_o     = 1'b0;
        exc_misalign_o = 1'b0;
        exc_buserr_o   = 1'b0;
        waddr_o        = REG_ADDR_W'(NOP_REG_ADDR);
        we_o           = 1'b0;
        wdata_o        = ZERO_WORD;

        // Outputs are forced quiet while reset is held, even mid-access
        if (rst) begin
            case (state)
                ST_IDLE: begin
                    if (!(al_is_load || al_is_store)) begin
                        waddr_o = waddr_i;
                        we_o    = we_i;
                        wdata_o = wdata_i;
                    end else if (al_misalign) begin
                        exc_misalign_o = 1'b1;
                        waddr_o        = waddr_i;
                    end else begin
                        issue = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cnt == CNT_W'(TIMEOUT)) begin
                        exc_buserr_o = 1'b1;
                        waddr_o      = cur.waddr;
                        state_next   = ST_IDLE;
                    end else begin
                        issue = 1'b1;
                    end
                end
                ST_HOLD: begin
                    waddr_o = hold_waddr;
                    we_o    = hold_we;
                    wdata_o = hold_wdata;
                    if (!stall_i)
                        state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase

            if (issue) begin
                dm_req_o   = 1'b1;
                dm_we_o    = al_is_store;
                dm_addr_o  = {cur.addr[ADDR_W-1:2], 2'b00};
                dm_sel_o   = al_sel;
                dm_wdata_o = al_wdata;
                waddr_o    = cur.waddr;
                if (dm_ack_i) begin
                    complete   = 1'b1;
                    we_o       = al_is_load & cur.we;
                    wdata_o    = al_is_load ? al_load : ZERO_WORD;
                    state_next = stall_i ? ST_HOLD : ST_IDLE;
                end else begin
                    stallreq_o   = 1'b1;
                    load_pending = al_is_load;
                    state_next   = ST_WAIT;
                end
            end
        end

        waddr_id_o = waddr_o;
        wdata_id_o = wdata_o;
        we_id_o    = we_o & ~load_pending;
    end

    assign dbg_state_o = state;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: single-cycle vector table plus hand-written
// multi-cycle sequences (wait states, timeout, hold, reset mid-access).
module tb_mem_access;

    localparam int TO = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  mem_op_i;
    logic [31:0] mem_addr_i, store_data_i, wdata_i, dm_rdata_i;
    logic [4:0]  waddr_i;
    logic        we_i, stall_i, dm_ack_i;
    logic [4:0]  waddr_o, waddr_id_o;
    logic        we_o, we_id_o, stallreq_o, exc_misalign_o, exc_buserr_o;
    logic [31:0] wdata_o, wdata_id_o, dm_addr_o, dm_wdata_o;
    logic        dm_req_o, dm_we_o;
    logic [3:0]  dm_sel_o;
    logic [1:0]  dbg_state_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    mem_access #(.ADDR_W(32), .REG_ADDR_W(5), .TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i),
        .store_data_i(store_data_i), .waddr_i(waddr_i), .we_i(we_i), .wdata_i(wdata_i),
        .stall_i(stall_i), .waddr_o(waddr_o), .we_o(we_o), .wdata_o(wdata_o),
        .waddr_id_o(waddr_id_o), .we_id_o(we_id_o), .wdata_id_o(wdata_id_o),
        .stallreq_o(stallreq_o), .exc_misalign_o(exc_misalign_o), .exc_buserr_o(exc_buserr_o),
        .dm_req_o(dm_req_o), .dm_we_o(dm_we_o), .dm_addr_o(dm_addr_o), .dm_sel_o(dm_sel_o),
        .dm_wdata_o(dm_wdata_o), .dm_ack_i(dm_ack_i), .dm_rdata_i(dm_rdata_i),
        .dbg_state_o(dbg_state_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [4:0]  waddr;
        logic        we;
        logic [31:0] wdata;
        logic        ack;
        logic [31:0] rdata;
        logic        e_we;
        logic [31:0] e_wdata;
        logic [4:0]  e_waddr;
        logic        e_req;
        logic        e_dmwe;
        logic [31:0] e_addr;
        logic [3:0]  e_sel;
        logic [31:0] e_dmwdata;
        logic        e_mis;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] wa, input logic we, input logic [31:0] wd,
                         input logic ack, input logic [31:0] rd, input logic stall);
        mem_op_i     = op;
        mem_addr_i   = addr;
        store_data_i = sdata;
        waddr_i      = wa;
        we_i         = we;
        wdata_i      = wd;
        dm_ack_i     = ack;
        dm_rdata_i   = rd;
        stall_i      = stall;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //                op    addr          sdata         wa  we wdata         ack rdata         e_we e_wdata       e_wa e_req e_dmwe e_addr        e_sel    e_dmwdata     e_mis
        vecs[0]  = '{4'd0, 32'h0000_0000, 32'h0,         5'd3,  1, 32'h0000_1234, 0, 32'h0,         1, 32'h0000_1234, 5'd3,  0, 0, 32'h0,         4'b0000, 32'h0,         0};
        vecs[1]  = '{4'd1, 32'h0000_0101, 32'h0,         5'd4,  1, 32'h0,         1, 32'h1180_2233, 1, 32'hFFFF_FF80, 5'd4,  1, 0, 32'h0000_0100, 4'b1111, 32'h0,         0};
        vecs[2]  = '{4'd2, 32'h0000_0103, 32'h0,         5'd5,  1, 32'h0,         1, 32'h1122_33F0, 1, 32'h0000_00F0, 5'd5,  1, 0, 32'h0000_0100, 4'b1111, 32'h0,         0};
        vecs[3]  = '{4'd3, 32'h0000_0100, 32'h0,         5'd6,  1, 32'h0,         1, 32'h8001_1234, 1, 32'hFFFF_8001, 5'd6,  1, 0, 32'h0000_0100, 4'b1111, 32'h0,         0};
        vecs[4]  = '{4'd4, 32'h0000_0102, 32'h0,         5'd7,  1, 32'h0,         1, 32'hAAAA_BEEF, 1, 32'h0000_BEEF, 5'd7,  1, 0, 32'h0000_0100, 4'b1111, 32'h0,         0};
        vecs[5]  = '{4'd5, 32'h0000_0204, 32'h0,         5'd8,  1, 32'h0,         1, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 5'd8,  1, 0, 32'h0000_0204, 4'b1111, 32'h0,         0};
        vecs[6]  = '{4'd1, 32'h0000_0100, 32'h0,         5'd9,  0, 32'h0,         1, 32'h7F00_0000, 0, 32'h0000_007F, 5'd9,  1, 0, 32'h0000_0100, 4'b1111, 32'h0,         0};
        vecs[7]  = '{4'd6, 32'h0000_0203, 32'h1234_565A, 5'd10, 1, 32'h0,         1, 32'h0,         0, 32'h0,         5'd10, 1, 1, 32'h0000_0200, 4'b0001, 32'h5A5A_5A5A, 0};
        vecs[8]  = '{4'd6, 32'h0000_0200, 32'h0000_00C3, 5'd0,  0, 32'h0,         1, 32'h0,         0, 32'h0,         5'd0,  1, 1, 32'h0000_0200, 4'b1000, 32'hC3C3_C3C3, 0};
        vecs[9]  = '{4'd6, 32'h0000_0201, 32'h0000_0077, 5'd0,  0, 32'h0,         1, 32'h0,         0, 32'h0,         5'd0,  1, 1, 32'h0000_0200, 4'b0100, 32'h7777_7777, 0};
        vecs[10] = '{4'd7, 32'h0000_0302, 32'h1111_BEEF, 5'd1,  0, 32'h0,         1, 32'h0,         0, 32'h0,         5'd1,  1, 1, 32'h0000_0300, 4'b0011, 32'hBEEF_BEEF, 0};
        vecs[11] = '{4'd7, 32'h0000_0300, 32'h0000_CAFE, 5'd1,  0, 32'h0,         1, 32'h0,         0, 32'h0,         5'd1,  1, 1, 32'h0000_0300, 4'b1100, 32'hCAFE_CAFE, 0};
        vecs[12] = '{4'd8, 32'h0000_0404, 32'h0123_4567, 5'd2,  0, 32'h0,         1, 32'h0,         0, 32'h0,         5'd2,  1, 1, 32'h0000_0404, 4'b1111, 32'h0123_4567, 0};
        vecs[13] = '{4'd8, 32'h0000_0102, 32'h0123_4567, 5'd11, 1, 32'h0,         0, 32'h0,         0, 32'h0,         5'd11, 0, 0, 32'h0,         4'b0000, 32'h0,         1};
        vecs[14] = '{4'd3, 32'h0000_0101, 32'h0,         5'd12, 1, 32'h0,         1, 32'h1234_5678, 0, 32'h0,         5'd12, 0, 0, 32'h0,         4'b0000, 32'h0,         1};
        vecs[15] = '{4'd4, 32'h0000_0103, 32'h0,         5'd12, 1, 32'h0,         0, 32'h0,         0, 32'h0,         5'd12, 0, 0, 32'h0,         4'b0000, 32'h0,         1};
        vecs[16] = '{4'd5, 32'h0000_0102, 32'h0,         5'd12, 1, 32'h0,         0, 32'h0,         0, 32'h0,         5'd12, 0, 0, 32'h0,         4'b0000, 32'h0,         1};
        vecs[17] = '{4'd15,32'h0000_0102, 32'h0,         5'd13, 1, 32'h0000_CAFE, 1, 32'hFFFF_FFFF, 1, 32'h0000_CAFE, 5'd13, 0, 0, 32'h0,         4'b0000, 32'h0,         0};

        // reset: a pending LW on the inputs must not leak onto the outputs
        rst = 1'b0;
        drive(4'd5, 32'h100, 32'h0, 5'd7, 1, 32'h55, 0, 32'h0, 0);
        repeat (2) @(posedge clk);
        #4;
        check("rst_dm_req", 32'(dm_req_o), 32'h0);
        check("rst_stallreq", 32'(stallreq_o), 32'h0);
        check("rst_we", 32'(we_o), 32'h0);
        check("rst_waddr", 32'(waddr_o), 32'h0);
        check("rst_dm_addr", dm_addr_o, 32'h0);
        check("rst_state", 32'(dbg_state_o), 32'h0);
        @(posedge clk); #1;
        drive(4'd0, 32'h0, 32'h0, 5'd0, 0, 32'h0, 0, 32'h0, 0);
        rst = 1'b1;

        // single-cycle vectors
        for (int i = 0; i < 18; i++) begin
            @(posedge clk); #1;
            drive(vecs[i].op, vecs[i].addr, vecs[i].sdata, vecs[i].waddr, vecs[i].we,
                  vecs[i].wdata, vecs[i].ack, vecs[i].rdata, 0);
            #3;
            check($sformatf("v%0d_we", i), 32'(we_o), 32'(vecs[i].e_we));
            check($sformatf("v%0d_wdata", i), wdata_o, vecs[i].e_wdata);
            check($sformatf("v%0d_waddr", i), 32'(waddr_o), 32'(vecs[i].e_waddr));
            check($sformatf("v%0d_we_id", i), 32'(we_id_o), 32'(vecs[i].e_we));
            check($sformatf("v%0d_wdata_id", i), wdata_id_o, vecs[i].e_wdata);
            check($sformatf("v%0d_waddr_id", i), 32'(waddr_id_o), 32'(vecs[i].e_waddr));
            check($sformatf("v%0d_dm_req", i), 32'(dm_req_o), 32'(vecs[i].e_req));
            check($sformatf("v%0d_dm_we", i), 32'(dm_we_o), 32'(vecs[i].e_dmwe));
            check($sformatf("v%0d_dm_addr", i), dm_addr_o, vecs[i].e_addr);
            check($sformatf("v%0d_dm_sel", i), 32'(dm_sel_o), 32'(vecs[i].e_sel));
            check($sformatf("v%0d_dm_wdata", i), dm_wdata_o, vecs[i].e_dmwdata);
            check($sformatf("v%0d_misalign", i), 32'(exc_misalign_o), 32'(vecs[i].e_mis));
            check($sformatf("v%0d_stallreq", i), 32'(stallreq_o), 32'h0);
            check($sformatf("v%0d_buserr", i), 32'(exc_buserr_o), 32'h0);
        end
        @(posedge clk); #1;
        drive(4'd0, 32'h0, 32'h0, 5'd0, 0, 32'h0, 0, 32'h0, 0);
        #3;
        check("post_vec_misalign_clear", 32'(exc_misalign_o), 32'h0);
        check("post_vec_state", 32'(dbg_state_o), 32'h0);

        // LHU acked after 3 stalled cycles
        @(posedge clk); #1;
        drive(4'd4, 32'h102, 32'h0, 5'd9, 1, 32'h0, 0, 32'hAAAA_BEEF, 0);
        for (int c = 0; c < 3; c++) begin
            #3;
            check($sformatf("lhu_c%0d_stallreq", c), 32'(stallreq_o), 32'h1);
            check($sformatf("lhu_c%0d_we_id", c), 32'(we_id_o), 32'h0);
            check($sformatf("lhu_c%0d_dm_req", c), 32'(dm_req_o), 32'h1);
            check($sformatf("lhu_c%0d_dm_addr", c), dm_addr_o, 32'h100);
            @(posedge clk); #1;
        end
        dm_ack_i = 1'b1;
        #3;
        check("lhu_ack_stallreq", 32'(stallreq_o), 32'h0);
        check("lhu_ack_we", 32'(we_o), 32'h1);
        check("lhu_ack_wdata", wdata_o, 32'h0000_BEEF);
        check("lhu_ack_we_id", 32'(we_id_o), 32'h1);
        check("lhu_ack_wdata_id", wdata_id_o, 32'h0000_BEEF);
        @(posedge clk); #1;
        drive(4'd0, 32'h0, 32'h0, 5'd0, 0, 32'h0, 0, 32'h0, 0);
        #3;
        check("lhu_done_state", 32'(dbg_state_o), 32'h0);
        check("lhu_done_dm_req", 32'(dm_req_o), 32'h0);

        // bus timeout: TO waiting cycles, then one error cycle
        @(posedge clk); #1;
        drive(4'd5, 32'h100, 32'h0, 5'd3, 1, 32'h0, 0, 32'h0, 0);
        #3;
        check("to_issue_req", 32'(dm_req_o), 32'h1);
        for (int i = 0; i < TO; i++) begin
            @(posedge clk); #4;
            check($sformatf("to_wait%0d_req", i), 32'(dm_req_o), 32'h1);
            check($sformatf("to_wait%0d_buserr", i), 32'(exc_buserr_o), 32'h0);
        end
        @(posedge clk); #4;
        check("to_buserr", 32'(exc_buserr_o), 32'h1);
        check("to_req_drop", 32'(dm_req_o), 32'h0);
        check("to_we", 32'(we_o), 32'h0);
        check("to_stallreq", 32'(stallreq_o), 32'h0);
        drive(4'd0, 32'h0, 32'h0, 5'd0, 0, 32'h0, 0, 32'h0, 0);
        @(posedge clk); #4;
        check("to_buserr_pulse_end", 32'(exc_buserr_o), 32'h0);
        check("to_state_idle", 32'(dbg_state_o), 32'h0);

        // zero-wait LW completing under stall_i -> HOLD for two cycles
        @(posedge clk); #1;
        drive(4'd5, 32'h104, 32'h0, 5'd5, 1, 32'h0, 1, 32'h1357_9BDF, 1);
        #3;
        check("hold_done_wdata", wdata_o, 32'h1357_9BDF);
        check("hold_done_stallreq", 32'(stallreq_o), 32'h0);
        exp_q.push_back(32'h1357_9BDF);
        exp_q.push_back(32'h1357_9BDF);
        @(posedge clk); #1;
        dm_rdata_i = 32'h0;
        #3;
        check("hold1_state", 32'(dbg_state_o), 32'h2);
        check("hold1_dm_req", 32'(dm_req_o), 32'h0);
        check("hold1_wdata", wdata_o, exp_q.pop_front());
        check("hold1_we", 32'(we_o), 32'h1);
        check("hold1_waddr", 32'(waddr_o), 32'h5);
        @(posedge clk); #1;
        stall_i = 1'b0;
        #3;
        check("hold2_dm_req", 32'(dm_req_o), 32'h0);
        check("hold2_wdata", wdata_o, exp_q.pop_front());
        @(posedge clk); #1;
        drive(4'd0, 32'h0, 32'h0, 5'd0, 0, 32'h0, 0, 32'h0, 0);
        #3;
        check("hold_exit_state", 32'(dbg_state_o), 32'h0);

        // reset asserted in the middle of WAIT
        @(posedge clk); #1;
        drive(4'd5, 32'h100, 32'h0, 5'd3, 1, 32'h0, 0, 32'h0, 0);
        @(posedge clk); #3;
        check("rstw_wait_req", 32'(dm_req_o), 32'h1);
        rst = 1'b0;
        #1;
        check("rstw_req", 32'(dm_req_o), 32'h0);
        check("rstw_stallreq", 32'(stallreq_o), 32'h0);
        check("rstw_buserr", 32'(exc_buserr_o), 32'h0);
        check("rstw_state", 32'(dbg_state_o), 32'h0);
        @(posedge clk); #1;
        drive(4'd0, 32'h0, 32'h0, 5'd0, 0, 32'h0, 0, 32'h0, 0);
        rst = 1'b1;
        #3;
        check("rstw_after_req", 32'(dm_req_o), 32'h0);
        check("rstw_after_buserr", 32'(exc_buserr_o), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
